ili9341_pattern_gen: RTL and testbench
======================================

# ili9341_pattern_gen

Upstream pixel source for the ILI9341 SPI display path. It generates one full frame of RGB565 pixels, in raster order, from a selectable test pattern. It replaces the fixed-colour register in the display top level: it presents one pixel at a time, advances on a one-cycle request strobe from the display controller, and flags the end of the frame.

## Interface
Parameters:
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- PIXEL_SIZE, 16, pixel width (RGB565)
- BAR_WIDTH, 40, colour-bar width in pixels (H_RES/8)
- CHECK_LOG2, 4, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle strobe; begins a frame
- pattern_sel  in  2  0 solid, 1 colour bars, 2 checkerboard, 3 gradient
- solid_color  in  PIXEL_SIZE  colour used by pattern 0
- pixel_req  in  1  one-cycle strobe from the controller: current pixel consumed, advance
- pixel_data  out  PIXEL_SIZE  current pixel
- pixel_valid  out  1  pixel_data holds a frame pixel not yet consumed
- frame_done  out  1  last pixel consumed; held until the next start or reset
- busy  out  1  high in LOAD and STREAM
- x  out  clog2(H_RES)  column of the current pixel
- y  out  clog2(V_RES)  row of the current pixel

## Operation
- State machine: IDLE -> LOAD -> STREAM -> DONE.
  - IDLE: `start` moves the block to LOAD.
  - DONE: `start` moves the block to LOAD (restart).
- LOAD, one cycle:
  - latch pattern_sel and solid_color;
  - set x=0, y=0;
  - register pixel(0,0) into pixel_data;
  - move to STREAM.
- STREAM, on pixel_req:
  - if x<H_RES-1, then x+1;
  - otherwise x=0 and y+1;
  - pixel_data updates to the pixel at the new (x,y).
- pixel_req at x=H_RES-1, y=V_RES-1 (last pixel): move to DONE; pixel_valid goes low and frame_done goes high.
- Ignored inputs:
  - pixel_req outside STREAM;
  - start in LOAD or STREAM;
  - changes to pattern_sel or solid_color after LOAD (the latched values hold for the whole frame).
- Pattern rules (RGB565):
  - Solid: latched solid_color.
  - Bars: index = x / BAR_WIDTH, clamped to 7. Index 0..7 maps to FFFF, FFE0, 07FF, 07E0, F811F → F81F, F800, 001F, 0000 (white, yellow, cyan, green, magenta, red, blue, black).
  - Checkerboard: FFFF if x[CHECK_LOG2]^y[CHECK_LOG2] is 1, else 0000.
  - Gradient: R=x[8:4], G=y[7:2], B=~x[8:4]. The bit selections are defined for the default resolution only.
- Frame size: exactly H_RES*V_RES pixels are presented. The pixel counters never wrap silently.

## Timing
- Reset values: pixel_data=0, pixel_valid=0, frame_done=0, busy=0, x=0, y=0, state=IDLE.
- Reset takes effect immediately, including in the middle of a frame; the frame is abandoned.
- start at edge N: LOAD after N. pixel_valid=1 and pixel_data=pixel(0,0) after N+1.
- pixel_req at edge M (in STREAM): the next pixel, x, and y are valid after M. Latency is 1 cycle.
- pixel_req may be asserted on consecutive cycles; every asserted cycle advances exactly one pixel.
- frame_done and the deassertion of pixel_valid occur on the edge that samples the last pixel_req.
- start in DONE: frame_done clears on that edge (state LOAD); the new frame behaves as from IDLE.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset and solid: reset with all outputs checked at 0; then pattern_sel=0, solid_color=07FF, start, and 76800 back-to-back pixel_req -> every pixel is 07FF; frame_done rises after request 76800; pixel_valid is low from then on.
- Colour bars: pattern_sel=1; step requests -> x=0: FFFF; x=39: FFFF; x=40: FFE0; x=319: 0000; at row 1, x=0: FFFF.
- Checkerboard and gradient:
  - pattern_sel=2 -> (15,0)=0000, (16,0)=FFFF, (16,16)=0000.
  - pattern_sel=3 -> (319,239)=9F6C.
- Ignored inputs: mid-frame, change pattern_sel, pulse start, and issue pixel_req while in IDLE and DONE -> the frame is unaffected, the pixel count is unchanged, and no advance occurs outside STREAM.
- Reset and restart:
  - assert rst at pixel 1000 -> all outputs return to reset values immediately;
  - start a new frame -> it begins at (0,0);
  - start in DONE -> frame_done clears and pixel(0,0) is valid 2 cycles after start.

Source files
------------

// File: rtl/ili9341_pattern_gen_if.sv
// Pixel-source bus between the display controller and the pattern generator.
//   master (controller): drives start, pattern_sel, solid_color and pixel_req;
//                        observes pixel_data, pixel_valid, frame_done, busy, x and y.
//   slave  (generator):  the reverse directions.
interface ili9341_pattern_gen_if #(
  parameter int unsigned PIXEL_SIZE = 16,
  parameter int unsigned X_W        = 9,
  parameter int unsigned Y_W        = 8
);
  logic                  start;
  logic [1:0]            pattern_sel;
  logic [PIXEL_SIZE-1:0] solid_color;
  logic                  pixel_req;
  logic [PIXEL_SIZE-1:0] pixel_data;
  logic                  pixel_valid;
  logic                  frame_done;
  logic                  busy;
  logic [X_W-1:0]        x;
  logic [Y_W-1:0]        y;

  modport master (
    output start, pattern_sel, solid_color, pixel_req,
    input  pixel_data, pixel_valid, frame_done, busy, x, y
  );

  modport slave (
    input  start, pattern_sel, solid_color, pixel_req,
    output pixel_data, pixel_valid, frame_done, busy, x, y
  );
endinterface

// File: rtl/ili9341_pattern_gen.sv
// Raster-order RGB565 test-pattern source for the ILI9341 display path.
// Presents one registered pixel at a time and advances on each pixel_req.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of ili9341_pattern_gen_if
//              in  start, pattern_sel, solid_color, pixel_req
//              out pixel_data, pixel_valid, frame_done, busy, x, y
module ili9341_pattern_gen #(
  parameter int unsigned H_RES      = 320,
  parameter int unsigned V_RES      = 240,
  parameter int unsigned PIXEL_SIZE = 16,
  parameter int unsigned BAR_WIDTH  = 40,
  parameter int unsigned CHECK_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ili9341_pattern_gen_if.slave  bus
);

  localparam int unsigned X_W = $clog2(H_RES);
  localparam int unsigned Y_W = $clog2(V_RES);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic [1:0]            r_sel,   w_sel;
  logic [PIXEL_SIZE-1:0] r_color, w_color;
  logic [X_W-1:0]        r_x,     w_x;
  logic [Y_W-1:0]        r_y,     w_y;
  logic [PIXEL_SIZE-1:0] r_data,  w_data;
  logic                  r_valid, w_valid;
  logic                  r_done,  w_done;
  logic                  r_busy,  w_busy;

  // Pattern colour at (px, py). Gradient bit picks assume the default 320x240 raster.
  function automatic logic [PIXEL_SIZE-1:0] f_pixel(
    input logic [1:0]            sel,
    input logic [PIXEL_SIZE-1:0] color,
    input logic [X_W-1:0]        px,
    input logic [Y_W-1:0]        py
  );
    logic [X_W-1:0]        bar;
    logic [PIXEL_SIZE-1:0] pix;
    bar = px / X_W'(BAR_WIDTH);
    pix = '0;
    case (sel)
      2'd0: pix = color;
      2'd1: begin
        if (bar > X_W'(7)) begin
          pix = PIXEL_SIZE'(16'h0000);
        end else begin
          case (bar[2:0])
            3'd0: pix = PIXEL_SIZE'(16'hFFFF);
            3'd1: pix = PIXEL_SIZE'(16'hFFE0);
            3'd2: pix = PIXEL_SIZE'(16'h07FF);
            3'd3: pix = PIXEL_SIZE'(16'h07E0);
            3'd4: pix = PIXEL_SIZE'(16'hF81F);
            3'd5: pix = PIXEL_SIZE'(16'hF800);
            3'd6: pix = PIXEL_SIZE'(16'h001F);
            3'd7: pix = PIXEL_SIZE'(16'h0000);
          endcase
        end
      end
      2'd2: pix = (px[CHECK_LOG2] ^ py[CHECK_LOG2]) ? '1 : '0;
      2'd3: pix = PIXEL_SIZE'({px[8:4], py[7:2], ~px[8:4]});
    endcase
    return pix;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_color = r_color;
    w_x     = r_x;
    w_y     = r_y;
    w_data  = r_data;
    w_valid = r_valid;
    w_done  = r_done;
    w_busy  = r_busy;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state = S_LOAD;
          w_done  = 1'b0;
          w_valid = 1'b0;
          w_busy  = 1'b1;
        end
      end

      // Latch the frame configuration and use it straight away for pixel (0,0).
      S_LOAD: begin
        w_sel   = bus.pattern_sel;
        w_color = bus.solid_color;
        w_x     = '0;
        w_y     = '0;
        w_data  = f_pixel(bus.pattern_sel, bus.solid_color, '0, '0);
        w_valid = 1'b1;
        w_state = S_STREAM;
      end

      S_STREAM: begin
        if (bus.pixel_req) begin
          if ((r_x == X_LAST) && (r_y == Y_LAST)) begin
            // Last pixel consumed: counters hold rather than wrap.
            w_state = S_DONE;
            w_valid = 1'b0;
            w_done  = 1'b1;
            w_busy  = 1'b0;
          end else if (r_x == X_LAST) begin
            w_x    = '0;
            w_y    = r_y + Y_W'(1);
            w_data = f_pixel(r_sel, r_color, '0, r_y + Y_W'(1));
          end else begin
            w_x    = r_x + X_W'(1);
            w_data = f_pixel(r_sel, r_color, r_x + X_W'(1), r_y);
          end
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_color <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_color <= w_color;
      r_x     <= w_x;
      r_y     <= w_y;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  assign bus.pixel_data  = r_data;
  assign bus.pixel_valid = r_valid;
  assign bus.frame_done  = r_done;
  assign bus.busy        = r_busy;
  assign bus.x           = r_x;
  assign bus.y           = r_y;

endmodule

// File: tb/tb_ili9341_pattern_gen.sv
// Directed self-checking bench for ili9341_pattern_gen. A second instance runs
// a gradient frame alongside the solid frame so both full frames share cycles.
module tb_ili9341_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ili9341_pattern_gen_if #(.PIXEL_SIZE(16), .X_W(9), .Y_W(8)) bus_a ();
  ili9341_pattern_gen_if #(.PIXEL_SIZE(16), .X_W(9), .Y_W(8)) bus_b ();

  ili9341_pattern_gen dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  ili9341_pattern_gen dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    bus_a.pixel_req = 1'b1;
    repeat (n) tick();
    bus_a.pixel_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(bus_a.pixel_data),  'h0);
    check({tag, "_valid"}, 32'(bus_a.pixel_valid), 'h0);
    check({tag, "_done"},  32'(bus_a.frame_done),  'h0);
    check({tag, "_busy"},  32'(bus_a.busy),        'h0);
    check({tag, "_x"},     32'(bus_a.x),           'h0);
    check({tag, "_y"},     32'(bus_a.y),           'h0);
  endtask

  initial begin
    int bad_pix;
    int bad_xy;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.pattern_sel = 2'd0; bus_a.solid_color = '0; bus_a.pixel_req = 1'b0;
    bus_b.start = 1'b0; bus_b.pattern_sel = 2'd0; bus_b.solid_color = '0; bus_b.pixel_req = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    rst = 1'b0;
    tick();

    // Solid 07FF on dut_a, gradient on dut_b, full frames back-to-back.
    bus_a.pattern_sel = 2'd0; bus_a.solid_color = 16'h07FF;
    bus_b.pattern_sel = 2'd3; bus_b.solid_color = 16'h1234;
    bus_a.start = 1'b1; bus_b.start = 1'b1;
    tick();
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    check("load_busy",  32'(bus_a.busy),        'h1);
    check("load_valid", 32'(bus_a.pixel_valid), 'h0);
    tick();
    check("solid_first_valid", 32'(bus_a.pixel_valid), 'h1);
    check("solid_first_data",  32'(bus_a.pixel_data),  'h07FF);
    check("grad_0_0",          32'(bus_b.pixel_data),  'h001F);
    bad_pix = 0;
    bad_xy  = 0;
    bus_a.pixel_req = 1'b1; bus_b.pixel_req = 1'b1;
    for (int i = 1; i <= 76800; i++) begin
      tick();
      if (i < 76800) begin
        if (bus_a.pixel_valid !== 1'b1 || bus_a.pixel_data !== 16'h07FF || bus_a.frame_done !== 1'b0)
          bad_pix++;
        if (int'(bus_a.x) != i % 320 || int'(bus_a.y) != i / 320)
          bad_xy++;
      end
      if (i == 16100) check("grad_100_50", 32'(bus_b.pixel_data), 'h3199);
      if (i == 76799) begin
        check("grad_319_239", 32'(bus_b.pixel_data), 'h9F6C);
        check("grad_last_x",  32'(bus_b.x), 319);
        check("grad_last_y",  32'(bus_b.y), 239);
        check("solid_not_done_early", 32'(bus_a.frame_done), 'h0);
      end
    end
    bus_a.pixel_req = 1'b0; bus_b.pixel_req = 1'b0;
    check("solid_pixels", 32'(bad_pix), 0);
    check("solid_xy",     32'(bad_xy),  0);
    check("solid_done",   32'(bus_a.frame_done),  'h1);
    check("solid_valid",  32'(bus_a.pixel_valid), 'h0);
    check("solid_busy",   32'(bus_a.busy),        'h0);
    check("grad_done",    32'(bus_b.frame_done),  'h1);

    // Requests in DONE do nothing.
    step(5);
    check("done_req_done",  32'(bus_a.frame_done),  'h1);
    check("done_req_valid", 32'(bus_a.pixel_valid), 'h0);
    check("done_req_busy",  32'(bus_a.busy),        'h0);

    // Restart from DONE with colour bars.
    bus_a.pattern_sel = 2'd1; bus_a.solid_color = 16'hABCD;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    check("restart_done_clr", 32'(bus_a.frame_done),  'h0);
    check("restart_busy",     32'(bus_a.busy),        'h1);
    check("restart_valid_lo", 32'(bus_a.pixel_valid), 'h0);
    tick();
    check("bars_x0_valid", 32'(bus_a.pixel_valid), 'h1);
    check("bars_x0",       32'(bus_a.pixel_data),  'hFFFF);
    check("bars_x0_x",     32'(bus_a.x), 0);
    step(39);
    check("bars_x39",   32'(bus_a.pixel_data), 'hFFFF);
    check("bars_x39_x", 32'(bus_a.x), 39);
    step(1);
    check("bars_x40",   32'(bus_a.pixel_data), 'hFFE0);

    // Mid-frame pattern change and start pulse are ignored.
    bus_a.pattern_sel = 2'd2;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    check("ign_start_x",    32'(bus_a.x), 40);
    check("ign_start_busy", 32'(bus_a.busy), 'h1);
    check("ign_start_data", 32'(bus_a.pixel_data), 'hFFE0);

    // Gapped requests to the end of row 0.
    for (int k = 0; k < 279; k++) begin
      bus_a.pixel_req = 1'b1;
      tick();
      bus_a.pixel_req = 1'b0;
      if (k % 3 == 0) tick();
    end
    check("bars_x319",   32'(bus_a.pixel_data), 'h0000);
    check("bars_x319_x", 32'(bus_a.x), 319);
    step(1);
    check("bars_row1",   32'(bus_a.pixel_data), 'hFFFF);
    check("bars_row1_x", 32'(bus_a.x), 0);
    check("bars_row1_y", 32'(bus_a.y), 1);
    step(680);
    check("pix1000_x",    32'(bus_a.x), 40);
    check("pix1000_y",    32'(bus_a.y), 3);
    check("pix1000_data", 32'(bus_a.pixel_data), 'hFFE0);

    // Asynchronous reset between clock edges.
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst = 1'b0;
    step(3);
    check("idle_req_x",     32'(bus_a.x), 0);
    check("idle_req_valid", 32'(bus_a.pixel_valid), 'h0);
    check("idle_req_busy",  32'(bus_a.busy), 'h0);

    // Checkerboard, with pixel_req held through IDLE and LOAD.
    bus_a.pattern_sel = 2'd2;
    bus_a.start = 1'b1;
    bus_a.pixel_req = 1'b1;
    tick();
    bus_a.start = 1'b0;
    tick();
    check("chk_load_x",     32'(bus_a.x), 0);
    check("chk_load_valid", 32'(bus_a.pixel_valid), 'h1);
    check("chk_0_0",        32'(bus_a.pixel_data), 'h0000);
    repeat (15) tick();
    check("chk_15_0",   32'(bus_a.pixel_data), 'h0000);
    check("chk_15_0_x", 32'(bus_a.x), 15);
    tick();
    check("chk_16_0",   32'(bus_a.pixel_data), 'hFFFF);
    repeat (5120) tick();
    bus_a.pixel_req = 1'b0;
    check("chk_16_16",   32'(bus_a.pixel_data), 'h0000);
    check("chk_16_16_x", 32'(bus_a.x), 16);
    check("chk_16_16_y", 32'(bus_a.y), 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
